coin_return_dispenser: RTL and testbench

Drives the coin-return hopper solenoids from the vending controller's one-cycle change requests (`rn` return nickel, `rd` return dime). Queues requests in per-coin pending counters, fires one coin at a time, and confirms each ejection with the chute drop sensor. Raises a sticky jam flag when a coin fails to drop. Sits between the vending FSM's `rn`/`rd` outputs and the hopper actuators/sensors.

---
 rtl/coin_return_dispenser_if.sv | 27 ++
 rtl/coin_return_dispenser.sv | 188 ++++++++++++++++++
 tb/tb_coin_return_dispenser.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/coin_return_dispenser_if.sv
// rtl/coin_return_dispenser_if.sv - request/sensor/actuator bundle between vending FSM, hopper and dispenser
interface coin_return_dispenser_if #(
  parameter int CNT_W = 3
);
  logic             rn;
  logic             rd;
  logic             n_drop;
  logic             d_drop;
  logic             clr_jam;
  logic             n_sol;
  logic             d_sol;
  logic [CNT_W-1:0] pend_n;
  logic [CNT_W-1:0] pend_d;
  logic             busy;
  logic             jam;
  logic             ovf;

  modport master (
    output rn, rd, n_drop, d_drop, clr_jam,
    input  n_sol, d_sol, pend_n, pend_d, busy, jam, ovf
  );

  modport slave (
    input  rn, rd, n_drop, d_drop, clr_jam,
    output n_sol, d_sol, pend_n, pend_d, busy, jam, ovf
  );
endinterface

// File: rtl/coin_return_dispenser.sv
// rtl/coin_return_dispenser.sv - queues nickel/dime return requests, pulses one hopper solenoid at a time
// and confirms each coin with the chute sensor, flagging a sticky jam when no coin drops.
module coin_return_dispenser #(
  parameter int PULSE_W = 4,
  parameter int GAP_W   = 2,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 3
) (
  input  logic                   clk,
  input  logic                   rst_,
  coin_return_dispenser_if.slave bus
);

  localparam int TMAX = (TIMEOUT > GAP_W) ? TIMEOUT : GAP_W;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0]    PULSE_LAST   = TW'(PULSE_W - 1);
  localparam logic [TW-1:0]    TIMEOUT_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]    GAP_LAST     = TW'(GAP_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRE_N,
    S_FIRE_D,
    S_WAIT_N,
    S_WAIT_D,
    S_GAP,
    S_JAM
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             dropped_q, dropped_d;
  logic [CNT_W-1:0] pend_n_q, pend_n_d;
  logic [CNT_W-1:0] pend_d_q, pend_d_d;
  logic             ovf_q, ovf_d;
  logic             n_sol_q, n_sol_d;
  logic             d_sol_q, d_sol_d;
  logic             busy_q, busy_d;
  logic             jam_q, jam_d;

  logic             is_n;
  logic             coin_drop;
  logic             dec_n;
  logic             dec_d;

  // One timer serves both the FIRE/WAIT jam timeout and the GAP off-time.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    dropped_d = dropped_q;
    dec_n     = 1'b0;
    dec_d     = 1'b0;
    is_n      = (state_q == S_FIRE_N) || (state_q == S_WAIT_N);
    coin_drop = is_n ? bus.n_drop : bus.d_drop;

    case (state_q)
      S_IDLE: begin
        if (pend_d_q != '0) begin
          state_d   = S_FIRE_D;
          timer_d   = '0;
          dropped_d = 1'b0;
        end else if (pend_n_q != '0) begin
          state_d   = S_FIRE_N;
          timer_d   = '0;
          dropped_d = 1'b0;
        end
      end

      S_FIRE_N, S_FIRE_D: begin
        timer_d = timer_q + TW'(1);
        if (coin_drop && !dropped_q) begin
          dropped_d = 1'b1;
          dec_n     = is_n;
          dec_d     = !is_n;
        end
        // The pulse always runs its full width, even after an early drop.
        if (timer_q == PULSE_LAST) begin
          if (dropped_d) begin
            state_d = S_GAP;
            timer_d = '0;
          end else begin
            state_d = is_n ? S_WAIT_N : S_WAIT_D;
          end
        end
      end

      S_WAIT_N, S_WAIT_D: begin
        timer_d = timer_q + TW'(1);
        if (coin_drop) begin
          dec_n   = is_n;
          dec_d   = !is_n;
          state_d = S_GAP;
          timer_d = '0;
        end else if (timer_q == TIMEOUT_LAST) begin
          state_d = S_JAM;
        end
      end

      S_GAP: begin
        timer_d = timer_q + TW'(1);
        if (timer_q == GAP_LAST) begin
          state_d = S_IDLE;
        end
      end

      S_JAM: begin
        if (bus.clr_jam) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A simultaneous request and confirmed coin cancel; saturation drops the request.
  always_comb begin
    pend_n_d = pend_n_q;
    pend_d_d = pend_d_q;
    ovf_d    = ovf_q;

    if (bus.rn && !dec_n) begin
      if (pend_n_q == CNT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        pend_n_d = pend_n_q + CNT_W'(1);
      end
    end else if (!bus.rn && dec_n) begin
      pend_n_d = pend_n_q - CNT_W'(1);
    end

    if (bus.rd && !dec_d) begin
      if (pend_d_q == CNT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        pend_d_d = pend_d_q + CNT_W'(1);
      end
    end else if (!bus.rd && dec_d) begin
      pend_d_d = pend_d_q - CNT_W'(1);
    end
  end

  always_comb begin
    n_sol_d = (state_d == S_FIRE_N);
    d_sol_d = (state_d == S_FIRE_D);
    jam_d   = (state_d == S_JAM);
    busy_d  = (state_d != S_IDLE) || (pend_n_d != '0) || (pend_d_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      dropped_q <= 1'b0;
      pend_n_q  <= '0;
      pend_d_q  <= '0;
      ovf_q     <= 1'b0;
      n_sol_q   <= 1'b0;
      d_sol_q   <= 1'b0;
      busy_q    <= 1'b0;
      jam_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      dropped_q <= dropped_d;
      pend_n_q  <= pend_n_d;
      pend_d_q  <= pend_d_d;
      ovf_q     <= ovf_d;
      n_sol_q   <= n_sol_d;
      d_sol_q   <= d_sol_d;
      busy_q    <= busy_d;
      jam_q     <= jam_d;
    end
  end

  assign bus.n_sol  = n_sol_q;
  assign bus.d_sol  = d_sol_q;
  assign bus.pend_n = pend_n_q;
  assign bus.pend_d = pend_d_q;
  assign bus.busy   = busy_q;
  assign bus.jam    = jam_q;
  assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_coin_return_dispenser.sv
// tb/tb_coin_return_dispenser.sv - vector table, directed corner sequences and randomized traffic
// checked against a coin-level reference model of the dispenser.
module tb_coin_return_dispenser;

  localparam int PULSE_W = 4;
  localparam int GAP_W   = 2;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 3;
  localparam int MAXC    = 7;

  // Input vector bits: {rst_, rn, rd, n_drop, d_drop, clr_jam}
  localparam logic [5:0] RS  = 6'b100000;
  localparam logic [5:0] RN  = 6'b010000;
  localparam logic [5:0] RD  = 6'b001000;
  localparam logic [5:0] ND  = 6'b000100;
  localparam logic [5:0] DD  = 6'b000010;
  localparam logic [5:0] CLR = 6'b000001;

  logic clk = 1'b0;
  logic rst_ = 1'b0;

  coin_return_dispenser_if #(.CNT_W(CNT_W)) bus ();

  coin_return_dispenser #(
    .PULSE_W(PULSE_W),
    .GAP_W  (GAP_W),
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk (clk),
    .rst_(rst_),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: coins owed, the coin in flight and its age, gap cycles left, jam flag.
  int m_own = 0, m_owd = 0;
  bit m_ovf = 0;
  int m_coin = 0;
  int m_age = 0;
  bit m_conf = 0;
  int m_gap = 0;
  bit m_jam = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] dut_out();
    return {bus.n_sol, bus.d_sol, bus.pend_n, bus.pend_d, bus.busy, bus.jam, bus.ovf};
  endfunction

  function automatic logic [10:0] model_out();
    logic ns, ds, bz;
    ns = (m_coin == 1) && (m_age < PULSE_W);
    ds = (m_coin == 2) && (m_age < PULSE_W);
    bz = (m_coin != 0) || (m_gap > 0) || m_jam || (m_own != 0) || (m_owd != 0);
    return {ns, ds, 3'(m_own), 3'(m_owd), bz, m_jam, m_ovf};
  endfunction

  task automatic model_step();
    bit dn, dd, drop;
    dn = 0;
    dd = 0;
    if (!rst_) begin
      m_own = 0; m_owd = 0; m_ovf = 0; m_coin = 0; m_age = 0; m_conf = 0; m_gap = 0; m_jam = 0;
      return;
    end
    if (m_jam) begin
      if (bus.clr_jam) m_jam = 0;
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (m_coin != 0) begin
      drop = (m_coin == 1) ? bus.n_drop : bus.d_drop;
      if (drop && !m_conf) begin
        m_conf = 1;
        if (m_coin == 1) dn = 1; else dd = 1;
      end
      if (m_age < PULSE_W - 1) m_age++;
      else if (m_conf) begin m_coin = 0; m_gap = GAP_W; end
      else if (m_age == TIMEOUT - 1) begin m_coin = 0; m_jam = 1; end
      else m_age++;
    end else if (m_owd > 0) begin
      m_coin = 2; m_age = 0; m_conf = 0;
    end else if (m_own > 0) begin
      m_coin = 1; m_age = 0; m_conf = 0;
    end
    if (bus.rn && !dn) begin
      if (m_own == MAXC) m_ovf = 1; else m_own++;
    end else if (!bus.rn && dn) m_own--;
    if (bus.rd && !dd) begin
      if (m_owd == MAXC) m_ovf = 1; else m_owd++;
    end else if (!bus.rd && dd) m_owd--;
  endtask

  task automatic drive(input logic [5:0] in);
    {rst_, bus.rn, bus.rd, bus.n_drop, bus.d_drop, bus.clr_jam} = in;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic step(input logic [5:0] in);
    drive(in);
    chk("model", 32'(dut_out()), 32'(model_out()));
    @(negedge clk);
  endtask

  // Drops follow the solenoids so every fired coin is confirmed in its first FIRE cycle.
  function automatic logic [5:0] auto_drop();
    return RS | (bus.n_sol ? ND : 6'b0) | (bus.d_sol ? DD : 6'b0);
  endfunction

  typedef struct {
    logic [5:0]  in;
    logic [10:0] exp;   // {n_sol, d_sol, pend_n, pend_d, busy, jam, ovf}
  } vec_t;

  vec_t tbl[11];

  initial begin
    int k;
    bit ok;
    int rise_t[$];
    int rise_c[$];
    int overlap;
    logic pn, pdv;
    bit done;
    logic [5:0] in;

    tbl[0]  = '{6'b000000,   11'b00_000_000_000};
    tbl[1]  = '{RS | RD,     11'b00_000_001_100};
    tbl[2]  = '{RS,          11'b01_000_001_100};
    tbl[3]  = '{RS,          11'b01_000_001_100};
    tbl[4]  = '{RS | DD,     11'b01_000_000_100};
    tbl[5]  = '{RS,          11'b01_000_000_100};
    tbl[6]  = '{RS,          11'b00_000_000_100};
    tbl[7]  = '{RS,          11'b00_000_000_100};
    tbl[8]  = '{RS,          11'b00_000_000_000};
    tbl[9]  = '{RS | DD | ND,11'b00_000_000_000};
    tbl[10] = '{RS | RN | RD,11'b00_001_001_100};

    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].in);
      chk($sformatf("vec%0d", i), 32'(dut_out()), 32'(tbl[i].exp));
      @(negedge clk);
    end

    // Second nickel: expect dispense order D, N, N on a 7-cycle period, never overlapping.
    overlap = 0;
    pn = 1'b0;
    pdv = 1'b0;
    for (int t = 0; t < 30; t++) begin
      step(t == 0 ? (RS | RN) : auto_drop());
      if (bus.n_sol && bus.d_sol) overlap++;
      if (bus.d_sol && !pdv) begin rise_t.push_back(t); rise_c.push_back(2); end
      if (bus.n_sol && !pn) begin rise_t.push_back(t); rise_c.push_back(1); end
      pn = bus.n_sol;
      pdv = bus.d_sol;
    end
    chk("order_len", rise_c.size(), 3);
    if (rise_c.size() == 3) begin
      chk("order0", rise_c[0], 2);
      chk("order1", rise_c[1], 1);
      chk("order2", rise_c[2], 1);
      chk("period1", rise_t[1] - rise_t[0], 7);
      chk("period2", rise_t[2] - rise_t[1], 7);
    end
    chk("overlap", overlap, 0);
    chk("idle_busy", bus.busy, 0);

    // Late drop: confirmed in the third WAIT cycle.
    step(RS | RN);
    ok = 0;
    for (int t = 0; t < 5 && !ok; t++) begin step(RS); ok = bus.n_sol; end
    chk("late_fire", ok, 1);
    ok = 0;
    for (int t = 0; t < 10 && !ok; t++) begin step(RS); ok = !bus.n_sol; end
    chk("late_fall", ok, 1);
    step(RS);
    step(RS);
    step(RS | ND);
    chk("late_pend", bus.pend_n, 0);
    chk("late_nojam", bus.jam, 0);
    for (int t = 0; t < 4; t++) step(RS);

    // Jam: no dime drop; jam rises 16 cycles after FIRE_D entry.
    step(RS | RD);
    ok = 0;
    for (int t = 0; t < 5 && !ok; t++) begin step(RS); ok = bus.d_sol; end
    chk("jam_fire", ok, 1);
    k = 0;
    while (k < 40 && !bus.jam) begin step(RS); k++; end
    chk("jam_latency", k, 16);
    chk("jam_pend_d", bus.pend_d, 1);
    step(RS | RN);
    chk("jam_req_n", bus.pend_n, 1);
    chk("jam_hold", bus.jam, 1);
    step(RS | CLR);
    chk("jam_clear", bus.jam, 0);
    step(RS);
    chk("retry_dime", {bus.d_sol, bus.n_sol}, 2'b10);
    for (int t = 0; t < 25; t++) step(auto_drop());

    // Saturation while jammed, then a request cancelling a confirmed nickel at count 7.
    step(RS | RD);
    k = 0;
    while (k < 40 && !bus.jam) begin step(RS); k++; end
    chk("sat_jammed", bus.jam, 1);
    for (int t = 0; t < 8; t++) step(RS | RN);
    chk("sat_pend_n", bus.pend_n, 7);
    chk("sat_ovf", bus.ovf, 1);
    step(RS | CLR);
    done = 0;
    for (int t = 0; t < 40 && !done; t++) begin
      if (bus.n_sol) begin
        step(RS | RN | ND);
        done = 1;
        chk("sat_stable", bus.pend_n, 7);
      end else begin
        step(auto_drop());
      end
    end
    chk("sat_reached", done, 1);

    // Reset mid-FIRE with three dimes owed.
    step(6'b0);
    step(RS | RD);
    step(RS | RD);
    step(RS | RD);
    chk("rst_setup", {bus.d_sol, bus.pend_d}, {1'b1, 3'd3});
    step(RD & 6'b0);
    chk("rst_outs", 32'(dut_out()), 32'(0));
    overlap = 0;
    for (int t = 0; t < 20; t++) begin
      step(RS);
      if (bus.n_sol || bus.d_sol) overlap++;
    end
    chk("rst_nofire", overlap, 0);

    // Randomized traffic against the model.
    for (int t = 0; t < 3000; t++) begin
      in = RS;
      if ($urandom_range(0, 399) == 0) in = 6'b0;
      if ($urandom_range(0, 5) == 0) in |= RN;
      if ($urandom_range(0, 6) == 0) in |= RD;
      if ($urandom_range(0, 7) == 0) in |= ND;
      if ($urandom_range(0, 7) == 0) in |= DD;
      if ($urandom_range(0, 15) == 0) in |= CLR;
      step(in);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
